apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_master_if.sv | 24 ++
 rtl/apb_timeout_counter.sv | 30 +++
 rtl/apb_master.sv | 106 ++++++++++
 tb/tb_apb_master.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding, default widths and register offsets for the APB master
package apb_pkg;

    localparam int DEFAULT_AMBA_WORD       = 32;
    localparam int DEFAULT_AMBA_ADDR_WIDTH = 20;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 16;

    // Register map of the peripheral this master normally talks to
    localparam logic [3:0] REG_CTRL           = 4'h0;
    localparam logic [3:0] REG_DATA_IN        = 4'h4;
    localparam logic [3:0] REG_CODEWORD_WIDTH = 4'h8;
    localparam logic [3:0] REG_NOISE          = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Only word-aligned addresses go out on the bus
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB bus signal bundle with master and slave views
interface apb_master_if #(
    parameter int AMBA_WORD       = apb_pkg::DEFAULT_AMBA_WORD,
    parameter int AMBA_ADDR_WIDTH = apb_pkg::DEFAULT_AMBA_ADDR_WIDTH
);
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - counts ACCESS wait cycles and flags the one that reaches the limit
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Wait-cycle counter, restarted whenever the master is outside ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the wait cycle that would make the total equal the limit
    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - command-to-APB bridge; optional ACCESS timeout under APB_TIMEOUT_EN
module apb_master
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = DEFAULT_AMBA_WORD,
    parameter int AMBA_ADDR_WIDTH = DEFAULT_AMBA_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    apb_master_if.master               apb
);
    apb_state_t state;
    apb_state_t state_next;

    logic cmd_fire;
    logic cmd_aligned;
    logic xfer_done;
    logic xfer_abort;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign cmd_aligned = is_word_aligned(cmd_addr[1:0]);
    assign xfer_done   = (state == ACCESS) && apb.PREADY;

`ifdef APB_TIMEOUT_EN
    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != ACCESS),
        .count_en ((state == ACCESS) && !apb.PREADY),
        .expired  (xfer_abort)
    );
`else
    assign xfer_abort = 1'b0;
`endif

    // Control outputs decode straight from the registered state so reset drops PSEL at once
    assign cmd_ready   = (state == IDLE);
    assign apb.PSEL    = (state != IDLE);
    assign apb.PENABLE = (state == ACCESS);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: unaligned commands never leave IDLE, SETUP always lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_aligned) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (xfer_done || xfer_abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus address/data capture and the one-cycle completion response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb.PADDR  <= '0;
            apb.PWRITE <= 1'b0;
            apb.PWDATA <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (cmd_fire && cmd_aligned) begin
                apb.PADDR  <= cmd_addr;
                apb.PWRITE <= cmd_write;
                apb.PWDATA <= cmd_wdata;
            end
            if (cmd_fire && !cmd_aligned) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
            end
            if (xfer_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= apb.PSLVERR;
                rsp_rdata <= (!apb.PWRITE && !apb.PSLVERR) ? apb.PRDATA : '0;
            end
            if (xfer_abort) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed vector bench for apb_master
module tb_apb_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    apb_master_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb ();

    apb_master #(
        .AMBA_WORD       (32),
        .AMBA_ADDR_WIDTH (20),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [19:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        bit          noise;
        int          exp_lat;
        int          exp_psel;
        int          exp_pen;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [8];
    logic [19:0] last_bus_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   psel_n   = 0;
        int   pen_n    = 0;
        int   acc_n    = 0;
        int   rsp_n    = 0;
        int   rsp_at   = -1;
        int   wait_n   = 0;
        int   late_sel = 0;
        logic unstable = 1'b0;
        logic got_err  = 1'b0;
        logic got_rdy  = 1'b0;
        logic [31:0] got_rdata = '0;

        @(negedge clk);
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk($sformatf("v%0d_ready_before", idx), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;

        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (apb.PSEL) begin
                psel_n++;
                if (apb.PADDR !== v.addr || apb.PWRITE !== v.write || apb.PWDATA !== v.wdata)
                    unstable = 1'b1;
            end
            if (apb.PENABLE) begin
                pen_n++;
                if (acc_n < v.waits) begin
                    apb.PREADY  = 1'b0;
                    apb.PSLVERR = 1'b1;
                    apb.PRDATA  = 32'hFFFF_FFFF;
                end else begin
                    apb.PREADY  = 1'b1;
                    apb.PSLVERR = v.slverr;
                    apb.PRDATA  = v.prdata;
                end
                acc_n++;
                if (v.noise) begin
                    cmd_valid = 1'b1;
                    cmd_write = ~v.write;
                    cmd_addr  = 20'h00020;
                    cmd_wdata = 32'h5555_AAAA;
                end
            end else begin
                apb.PREADY  = 1'b0;
                apb.PSLVERR = 1'b0;
                cmd_valid   = 1'b0;
            end
            if (rsp_valid) begin
                rsp_n++;
                if (rsp_at < 0) begin
                    rsp_at    = cyc;
                    got_err   = rsp_err;
                    got_rdata = rsp_rdata;
                    got_rdy   = cmd_ready;
                end
            end
            if (rsp_at > 0 && cyc >= rsp_at + 2) break;
        end
        cmd_valid   = 1'b0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;

        if (v.addr[1:0] == 2'b00) last_bus_addr = v.addr;

        chk($sformatf("v%0d_latency", idx), rsp_at, v.exp_lat);
        chk($sformatf("v%0d_psel_cycles", idx), psel_n, v.exp_psel);
        chk($sformatf("v%0d_penable_cycles", idx), pen_n, v.exp_pen);
        chk($sformatf("v%0d_rsp_pulses", idx), rsp_n, 32'd1);
        chk($sformatf("v%0d_rsp_err", idx), {31'd0, got_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_rsp_rdata", idx), got_rdata, v.exp_rdata);
        chk($sformatf("v%0d_ready_at_rsp", idx), {31'd0, got_rdy}, 32'd1);
        chk($sformatf("v%0d_bus_stable", idx), {31'd0, unstable}, 32'd0);
        chk($sformatf("v%0d_paddr_hold", idx), {12'd0, apb.PADDR}, {12'd0, last_bus_addr});
        chk($sformatf("v%0d_psel_low_after", idx), {30'd0, apb.PSEL, apb.PENABLE}, 32'd0);

        if (v.noise) begin
            repeat (3) begin
                @(negedge clk);
                if (apb.PSEL) late_sel++;
            end
            chk($sformatf("v%0d_busy_cmd_ignored", idx), late_sel, 32'd0);
        end
    endtask

    initial begin
        int seen;

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = '0;
        last_bus_addr = '0;

        //          wr    addr       wdata          waits slverr prdata        noise lat psel pen err rdata
        vecs[0] = '{1'b1, 20'h00004, 32'hDEAD_BEEF, 0,    1'b0, 32'h1234_5678, 0,    3,  2,   1,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 20'h00008, 32'h0,         3,    1'b0, 32'h0000_0007, 0,    6,  5,   4,  1'b0, 32'h7};
        vecs[2] = '{1'b1, 20'h0000C, 32'h1111_2222, 0,    1'b1, 32'h0,         0,    3,  2,   1,  1'b1, 32'h0};
        vecs[3] = '{1'b1, 20'h0000C, 32'h3333_4444, 2,    1'b0, 32'h0,         0,    5,  4,   3,  1'b0, 32'h0};
        vecs[4] = '{1'b0, 20'h00002, 32'h0,         0,    1'b0, 32'h0,         0,    1,  0,   0,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 20'hFFFFC, 32'h0,         1,    1'b0, 32'h0BAD_F00D, 1,    4,  3,   2,  1'b0, 32'h0BAD_F00D};
        vecs[6] = '{1'b1, 20'h00003, 32'hCAFE_0000, 0,    1'b0, 32'h0,         0,    1,  0,   0,  1'b1, 32'h0};
`ifdef APB_TIMEOUT_EN
        vecs[7] = '{1'b0, 20'h00008, 32'h0,         30,   1'b0, 32'h55,        0,    18, 17,  16, 1'b1, 32'h0};
`else
        vecs[7] = '{1'b0, 20'h00008, 32'h0,         20,   1'b0, 32'h55,        0,    23, 22,  21, 1'b0, 32'h55};
`endif

        repeat (3) @(negedge clk);
        chk("reset_psel",      {31'd0, apb.PSEL},    32'd0);
        chk("reset_penable",   {31'd0, apb.PENABLE}, 32'd0);
        chk("reset_pwrite",    {31'd0, apb.PWRITE},  32'd0);
        chk("reset_paddr",     {12'd0, apb.PADDR},   32'd0);
        chk("reset_pwdata",    apb.PWDATA,           32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid},   32'd0);
        chk("reset_rsp_rdata", rsp_rdata,            32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err},     32'd0);
        chk("reset_cmd_ready", {31'd0, cmd_ready},   32'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while the master is waiting in ACCESS
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 20'h00008;
        cmd_wdata = '0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_access", {30'd0, apb.PSEL, apb.PENABLE}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_psel",      {31'd0, apb.PSEL},    32'd0);
        chk("abort_penable",   {31'd0, apb.PENABLE}, 32'd0);
        chk("abort_paddr",     {12'd0, apb.PADDR},   32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready},   32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_bus_addr = '0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || apb.PSEL) seen++;
        end
        chk("abort_no_rsp", seen, 32'd0);

        run_vec(8, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
